trap_seq_ctrl: RTL and testbench

- Machine-mode trap sequencer for the rv32i core; owns the single write port of the zicsr register file.
- On a synchronous exception, pending interrupt or mret, it sequences the required CSR writes one per cycle: mepc, mcause, optional mtval, mstatus.
- It then issues a PC redirect.
- Between traps it arbitrates the CSR write port, granting it to the core's csrr* path only when idle.

---
 rtl/rv32_csr_pkg.sv | 31 +++
 rtl/trap_irq_prio.sv | 11 +
 rtl/trap_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_trap_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_csr_pkg.sv
// rv32_csr_pkg: machine-mode CSR addresses, mstatus fields, irq codes and trap sequencer states
package rv32_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP = 11;
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;
  typedef enum logic [2:0] {IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, WR_MRET, REDIRECT} seq_state_e;
  function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP+:2] = 2'b11;
    return r;
  endfunction
  function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE] = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP+:2] = 2'b11;
    return r;
  endfunction
endpackage

// File: rtl/trap_irq_prio.sv
// trap_irq_prio: fixed-priority encoder of masked interrupts, MEI > MSI > MTI
module trap_irq_prio
  import rv32_csr_pkg::*;
(
  input  logic [31:0] irq,
  output logic        valid,
  output logic [4:0]  code
);
  assign valid = |irq;
  assign code = irq[IRQ_MEI] ? IRQ_MEI : irq[IRQ_MSI] ? IRQ_MSI : irq[IRQ_MTI] ? IRQ_MTI : 5'd0;
endmodule

// File: rtl/trap_seq_ctrl.sv
// trap_seq_ctrl: M-mode trap/mret CSR write sequencer and PC redirect; define TRAP_SEQ_MTVAL_EN to add the mtval write
module trap_seq_ctrl
  import rv32_csr_pkg::*;
#(
  parameter logic [31:0] IRQ_MASK = 32'h0000_0888,
  parameter int          CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exc_req,
  input  logic [4:0]        exc_cause,
  input  logic [31:0]       exc_tval,
  input  logic [31:0]       pc_i,
  input  logic              mret_req,
  input  logic [31:0]       mstatus_i,
  input  logic [31:0]       mie_i,
  input  logic [31:0]       mip_i,
  input  logic [31:0]       mtvec_i,
  input  logic [31:0]       mepc_i,
  input  logic              core_csr_we,
  input  logic [CSR_AW-1:0] core_csr_addr,
  input  logic [31:0]       core_csr_wdata,
  output logic              core_csr_gnt,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic              busy,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              trap_ack
);
  seq_state_e state_q;
  logic is_irq_q, mret_q;
  logic [4:0] cause_q;
  logic [29:0] pc_q;
  logic [31:0] irq, base;
  logic irq_v, take_irq, idle, accept, vec;
  logic [4:0] irq_code;
  assign irq = mip_i & mie_i & IRQ_MASK;
  trap_irq_prio u_prio (.irq(irq), .valid(irq_v), .code(irq_code));
  assign take_irq = irq_v & mstatus_i[MSTATUS_MIE];
  assign idle = state_q == IDLE;
  assign accept = idle & (exc_req | mret_req | take_irq);
`ifdef TRAP_SEQ_MTVAL_EN
  logic [31:0] tval_q;
  logic unused_in;
  assign unused_in = ^pc_i[1:0];
  always_ff @(posedge clk)
    if (!rst_n) tval_q <= '0;
    else if (accept) tval_q <= exc_tval;
`else
  logic unused_in;
  assign unused_in = ^{pc_i[1:0], exc_tval};
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_irq_q <= 1'b0;
      mret_q <= 1'b0;
      cause_q <= '0;
      pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mret_q <= !exc_req & mret_req;
          is_irq_q <= !exc_req & !mret_req;
          cause_q <= exc_req ? exc_cause : irq_code;
          pc_q <= pc_i[31:2];
          state_q <= (exc_req | !mret_req) ? WR_MEPC : WR_MRET;
        end
        WR_MEPC: state_q <= WR_MCAUSE;
`ifdef TRAP_SEQ_MTVAL_EN
        WR_MCAUSE: state_q <= WR_MTVAL;
`else
        WR_MCAUSE: state_q <= WR_MSTATUS;
`endif
        WR_MTVAL: state_q <= WR_MSTATUS;
        WR_MSTATUS: state_q <= REDIRECT;
        WR_MRET: state_q <= REDIRECT;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = rst_n & !idle;
  assign core_csr_gnt = rst_n & idle & core_csr_we & !accept;
  assign csr_we = core_csr_gnt | (busy & state_q != REDIRECT);
  assign redirect_valid = rst_n & state_q == REDIRECT;
  assign trap_ack = redirect_valid;
  assign base = {mtvec_i[31:2], 2'b00};
  assign vec = is_irq_q & mtvec_i[1:0] == 2'b01;
  assign redirect_pc = !redirect_valid ? '0 : mret_q ? mepc_i : base + (vec ? {25'b0, cause_q, 2'b00} : 32'b0);
  always_comb begin
    csr_waddr = '0;
    csr_wdata = '0;
    if (rst_n)
      case (state_q)
        IDLE: if (core_csr_gnt) begin
          csr_waddr = core_csr_addr;
          csr_wdata = core_csr_wdata;
        end
        WR_MEPC: begin
          csr_waddr = CSR_AW'(CSR_MEPC);
          csr_wdata = {pc_q, 2'b00};
        end
        WR_MCAUSE: begin
          csr_waddr = CSR_AW'(CSR_MCAUSE);
          csr_wdata = {is_irq_q, 26'b0, cause_q};
        end
`ifdef TRAP_SEQ_MTVAL_EN
        WR_MTVAL: begin
          csr_waddr = CSR_AW'(CSR_MTVAL);
          csr_wdata = is_irq_q ? 32'b0 : tval_q;
        end
`endif
        WR_MSTATUS: begin
          csr_waddr = CSR_AW'(CSR_MSTATUS);
          csr_wdata = mstatus_trap(mstatus_i);
        end
        WR_MRET: begin
          csr_waddr = CSR_AW'(CSR_MSTATUS);
          csr_wdata = mstatus_mret(mstatus_i);
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_trap_seq_ctrl.sv
// tb_trap_seq_ctrl: randomized scoreboard bench for trap_seq_ctrl against a rule-level trap model
module tb_trap_seq_ctrl;
`ifdef TRAP_SEQ_MTVAL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  typedef struct {int cyc; logic [11:0] addr; logic [31:0] data; bit core;} wr_t;
  typedef struct {int cyc; logic [31:0] pc;} rd_t;
  logic clk = 0, rst_n = 0;
  logic exc_req = 0, mret_req = 0, core_csr_we = 0;
  logic [4:0] exc_cause = 0;
  logic [31:0] exc_tval = 0, pc_i = 0, mstatus_i = 0, mie_i = 0, mip_i = 0, mtvec_i = 0, mepc_i = 0;
  logic [11:0] core_csr_addr = 0;
  logic [31:0] core_csr_wdata = 0;
  logic core_csr_gnt, csr_we, busy, redirect_valid, trap_ack;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  int cyc = 0, checks = 0, failures = 0;
  wr_t wq[$];
  rd_t rq[$];

  trap_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .pc_i(pc_i), .mret_req(mret_req), .mstatus_i(mstatus_i), .mie_i(mie_i), .mip_i(mip_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .core_csr_we(core_csr_we), .core_csr_addr(core_csr_addr),
    .core_csr_wdata(core_csr_wdata), .core_csr_gnt(core_csr_gnt), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    rd_t r;
    checks++;
    if (csr_we) begin
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL csr_write unexpected: got addr=%h data=%h cyc=%0d, wanted none", csr_waddr, csr_wdata, cyc);
      end else begin
        e = wq.pop_front();
        if (csr_waddr !== e.addr || csr_wdata !== e.data || cyc != e.cyc || core_csr_gnt !== e.core) begin
          failures++;
          $display("FAIL csr_write: got addr=%h data=%h cyc=%0d gnt=%b, wanted addr=%h data=%h cyc=%0d gnt=%b",
                   csr_waddr, csr_wdata, cyc, core_csr_gnt, e.addr, e.data, e.cyc, e.core);
        end
      end
    end else if (core_csr_gnt !== 1'b0) begin
      failures++;
      $display("FAIL gnt_without_write: got gnt=%b, wanted 0 at cyc=%0d", core_csr_gnt, cyc);
    end
    if (redirect_valid || trap_ack) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL redirect unexpected: got pc=%h cyc=%0d, wanted none", redirect_pc, cyc);
      end else begin
        r = rq.pop_front();
        if (redirect_pc !== r.pc || cyc != r.cyc || trap_ack !== redirect_valid) begin
          failures++;
          $display("FAIL redirect: got pc=%h cyc=%0d ack=%b valid=%b, wanted pc=%h cyc=%0d ack=valid=1",
                   redirect_pc, cyc, trap_ack, redirect_valid, r.pc, r.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, wanted %h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) step();
    chk("wait_idle", {31'b0, busy}, 32'b0);
  endtask

  // Expected trap traffic derived from the architectural rules, accepted in cycle c
  task automatic expect_trap(input int c);
    logic [31:0] irq, ms, base;
    bit is_irq;
    logic [4:0] code;
    irq = mip_i & mie_i & 32'h888;
    ms = mstatus_i;
    base = mtvec_i & ~32'h3;
    if (!exc_req && mret_req) begin
      wq.push_back('{c + 1, 12'h300, (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0), 1'b0});
      rq.push_back('{c + 2, mepc_i});
      return;
    end
    is_irq = !exc_req;
    code = exc_req ? exc_cause : irq[11] ? 5'd11 : irq[3] ? 5'd3 : 5'd7;
    wq.push_back('{c + 1, 12'h341, pc_i & ~32'h3, 1'b0});
    wq.push_back('{c + 2, 12'h342, (is_irq ? 32'h8000_0000 : 32'h0) + code, 1'b0});
    if (LAT == 5) wq.push_back('{c + 3, 12'h343, is_irq ? 32'h0 : exc_tval, 1'b0});
    wq.push_back('{c + LAT - 1, 12'h300, (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0), 1'b0});
    rq.push_back('{c + LAT, (is_irq && mtvec_i[1:0] == 2'b01) ? base + 4 * code : base});
  endtask

  task automatic txn();
    bit ack, trap;
    wait_idle();
    trap = exc_req || mret_req || ((mip_i & mie_i & 32'h888) != 0 && mstatus_i[3]);
    if (trap) begin
      expect_trap(cyc);
      ack = 0;
      for (int n = 0; n < 12 && !ack; n++) begin
        chk("busy", {31'b0, busy}, {31'b0, n > 0});
        if (trap_ack) ack = 1;
        else step();
      end
      if (!ack) begin
        failures++;
        $display("FAIL trap_ack timeout: got no ack, wanted ack within 12 cycles");
      end
      step();
      exc_req = 0;
      mret_req = 0;
      mip_i = 0;
      if (core_csr_we) begin
        wq.push_back('{cyc, core_csr_addr, core_csr_wdata, 1'b1});
        step();
      end
    end else begin
      if (core_csr_we) wq.push_back('{cyc, core_csr_addr, core_csr_wdata, 1'b1});
      step();
    end
    core_csr_we = 0;
  endtask

  initial begin
    step();
    chk("reset_outs", {csr_we, core_csr_gnt, busy, redirect_valid, trap_ack, csr_waddr, csr_wdata | redirect_pc}, 0);
    step();
    rst_n = 1;
    step();
    chk("post_reset_outs", {csr_we, core_csr_gnt, busy, redirect_valid, trap_ack, csr_waddr, csr_wdata | redirect_pc}, 0);
    mtvec_i = 32'h100; mstatus_i = 32'h8; exc_cause = 2; pc_i = 32'h404; exc_tval = 32'hBAD0_0004; exc_req = 1;
    core_csr_we = 1; core_csr_addr = 12'h340; core_csr_wdata = 32'hDEAD_BEEF;
    txn();
    mtvec_i = 32'h201; mie_i = 32'h80; mip_i = 32'h80; pc_i = 32'h1000;
    txn();
    mtvec_i = 32'h100; mie_i = 32'h888; mip_i = 32'h888;
    txn();
    mip_i = 32'h888; mstatus_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk("mie0_no_trap_busy", {31'b0, busy}, 32'b0);
      step();
    end
    mip_i = 0;
    mstatus_i = 32'h1880; mepc_i = 32'h500; mret_req = 1;
    txn();
    mstatus_i = 32'h8; pc_i = 32'h2000; exc_cause = 5; exc_req = 1;
    wq.push_back('{cyc + 1, 12'h341, 32'h2000, 1'b0});
    step();
    step();
    rst_n = 0;
    exc_req = 0;
    step();
    chk("abort_outs", {csr_we, core_csr_gnt, busy, redirect_valid, trap_ack, csr_waddr, csr_wdata | redirect_pc}, 0);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_idle_busy", {31'b0, busy}, 32'b0);
    end
    for (int t = 0; t < 120; t++) begin
      mstatus_i = $urandom;
      mie_i = $urandom & 32'hFFF;
      mip_i = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFF) : 32'h0;
      mtvec_i = $urandom;
      mepc_i = $urandom;
      pc_i = $urandom;
      exc_tval = $urandom;
      exc_cause = 5'($urandom_range(0, 31));
      exc_req = $urandom_range(0, 9) < 3;
      mret_req = $urandom_range(0, 9) < 2;
      core_csr_we = $urandom_range(0, 9) < 4;
      core_csr_addr = 12'($urandom);
      core_csr_wdata = $urandom;
      txn();
      exc_req = 0;
      mret_req = 0;
      mip_i = 0;
    end
    repeat (4) step();
    chk("queues_drained", wq.size() + rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
